// File: rtl/psum_drain.sv
// Partial-sum drain: accumulates per-column psum vectors across input tiles and
// streams each completed group out one column per handshake while the next group accumulates.
module psum_drain #(
    parameter int COL_WIDTH  = 13,
    parameter int ARRAY_SIZE = 8,
    parameter int ACC_WIDTH  = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                psum_valid,
    output logic                                psum_ready,
    input  logic [ARRAY_SIZE*COL_WIDTH*4-1:0]   psums,
    input  logic                                psum_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ACC_WIDTH-1:0]                out_data,
    output logic [$clog2(ARRAY_SIZE)-1:0]       out_col,
    output logic                                out_last
);

    localparam int PW = COL_WIDTH * 4;
    localparam int CW = $clog2(ARRAY_SIZE);
    localparam logic [CW-1:0] LAST_COL = CW'(ARRAY_SIZE - 1);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t               state;
    logic                 first;
    logic [ACC_WIDTH-1:0] acc       [ARRAY_SIZE];
    logic [ACC_WIDTH-1:0] drain_buf [ARRAY_SIZE];
    logic [ACC_WIDTH-1:0] ext       [ARRAY_SIZE];
    logic [ACC_WIDTH-1:0] sum       [ARRAY_SIZE];

    logic          in_fire;
    logic          out_fire;
    logic          load;
    logic [CW-1:0] col_inc;

    assign out_fire   = out_valid & out_ready;
    // A last beat may only load the buffer once its final word is leaving.
    assign psum_ready = (state == IDLE) | ~psum_last | (out_fire & out_last);
    assign in_fire    = psum_valid & psum_ready;
    assign load       = in_fire & psum_last;
    assign col_inc    = (out_col == LAST_COL) ? '0 : out_col + 1'b1;

    // The same sum feeds both the running accumulator and the drain buffer.
    always_comb begin
        for (int unsigned c = 0; c < ARRAY_SIZE; c++) begin
            ext[c] = '0;
            sum[c] = '0;
        end
        for (int unsigned c = 0; c < ARRAY_SIZE; c++) begin
            ext[c] = ACC_WIDTH'($signed(psums[c*PW +: PW]));
            sum[c] = (first ? '0 : acc[c]) + ext[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            first     <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            for (int unsigned c = 0; c < ARRAY_SIZE; c++) begin
                acc[c]       <= '0;
                drain_buf[c] <= '0;
            end
        end else begin
            if (in_fire) begin
                for (int unsigned c = 0; c < ARRAY_SIZE; c++) begin
                    acc[c] <= sum[c];
                end
                first <= psum_last;
            end

            // A load wins over the final out_fire so back-to-back groups have no bubble.
            if (load) begin
                for (int unsigned c = 0; c < ARRAY_SIZE; c++) begin
                    drain_buf[c] <= sum[c];
                end
                state     <= DRAIN;
                out_valid <= 1'b1;
                out_col   <= '0;
                out_data  <= sum[0];
                out_last  <= (ARRAY_SIZE == 1);
            end else if (out_fire) begin
                out_col  <= col_inc;
                out_data <= drain_buf[col_inc];
                if (out_last) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    out_last <= (col_inc == LAST_COL);
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: a reference model pushes expected drain words
// into a scoreboard queue on each accepted last beat; words are popped and compared on out_fire.
module tb_psum_drain;

    localparam int CWD  = 13;
    localparam int NCOL = 8;
    localparam int PW   = CWD * 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 psum_valid, psum_ready, psum_last;
    logic [NCOL*PW-1:0]   psums;
    logic                 out_valid, out_ready, out_last;
    logic [63:0]          out_data;
    logic [2:0]           out_col;

    logic                 w_psum_valid, w_psum_ready, w_psum_last;
    logic [NCOL*PW-1:0]   w_psums;
    logic                 w_out_valid, w_out_ready, w_out_last;
    logic [51:0]          w_out_data;
    logic [2:0]           w_out_col;

    always #5 clk = ~clk;

    psum_drain #(.COL_WIDTH(CWD), .ARRAY_SIZE(NCOL), .ACC_WIDTH(64)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psums(psums), .psum_last(psum_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_col(out_col), .out_last(out_last)
    );

    psum_drain #(.COL_WIDTH(CWD), .ARRAY_SIZE(NCOL), .ACC_WIDTH(52)) u_dut52 (
        .clk(clk), .rst_n(rst_n),
        .psum_valid(w_psum_valid), .psum_ready(w_psum_ready), .psums(w_psums), .psum_last(w_psum_last),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
        .out_col(w_out_col), .out_last(w_out_last)
    );

    typedef struct {
        logic [2:0]  col;
        logic [63:0] data;
        logic        last;
    } exp_t;

    exp_t   sb[$];
    int     tests = 0;
    int     fails = 0;
    int     valid_cycles = 0;
    bit     beat_taken;
    bit     ready_at_drive;
    longint beat [NCOL];
    longint macc [NCOL];
    bit     mfirst = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: sample at the falling edge, then return just after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        beat_taken = psum_valid && psum_ready;
        if (out_valid) valid_cycles++;
        if (out_valid && out_ready) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_word observed col=%0d data=%0h expected no word", out_col, out_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_col",  64'(out_col),  64'(e.col));
                chk("sb_data", out_data,      e.data);
                chk("sb_last", 64'(out_last), 64'(e.last));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input bit last, output int waited);
        for (int c = 0; c < NCOL; c++) psums[c*PW +: PW] = beat[c][PW-1:0];
        psum_valid = 1'b1;
        psum_last  = last;
        #1;
        ready_at_drive = psum_ready;
        waited = 0;
        beat_taken = 1'b0;
        while (!beat_taken && waited < 50) begin
            step();
            waited++;
        end
        psum_valid = 1'b0;
        psum_last  = 1'b0;
        chk("beat_accepted", 64'(beat_taken), 64'd1);
        if (beat_taken) begin
            for (int c = 0; c < NCOL; c++) begin
                macc[c] = mfirst ? beat[c] : macc[c] + beat[c];
                if (last) sb.push_back('{col: 3'(c), data: macc[c], last: (c == NCOL - 1)});
            end
            mfirst = last;
        end
    endtask

    task automatic drain_all(input string tag);
        for (int i = 0; i < 100 && sb.size() > 0; i++) step();
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int w;
        bit v0, r0;
        logic [2:0]  c0;
        logic [63:0] d0;

        rst_n = 1'b0;
        psum_valid = 1'b0; psum_last = 1'b0; psums = '0; out_ready = 1'b0;
        w_psum_valid = 1'b0; w_psum_last = 1'b0; w_psums = '0; w_out_ready = 1'b1;
        #12;
        chk("rst_psum_ready", 64'(psum_ready), 64'd1);
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_out_data",   out_data,        64'd0);
        chk("rst_out_col",    64'(out_col),    64'd0);
        chk("rst_out_last",   64'(out_last),   64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // Single-beat group of 5s
        out_ready = 1'b1;
        valid_cycles = 0;
        for (int c = 0; c < NCOL; c++) beat[c] = 5;
        send_beat(1'b1, w);
        chk("t1_latency_valid", 64'(out_valid), 64'd1);
        chk("t1_latency_col",   64'(out_col),   64'd0);
        chk("t1_col0_data",     out_data,       64'd5);
        repeat (12) step();
        chk("t1_valid_cycles",  64'(valid_cycles), 64'd8);
        chk("t1_drained",       64'(sb.size()),    64'd0);

        // Three-beat signed group
        for (int c = 0; c < NCOL; c++) beat[c] = 0;
        beat[0] = 100;  beat[3] = -1; send_beat(1'b0, w);
        beat[0] = -300;               send_beat(1'b0, w);
        beat[0] = 7;                  send_beat(1'b1, w);
        chk("t2_col0", out_data, 64'hFFFF_FFFF_FFFF_FF3F);
        repeat (3) step();
        chk("t2_col3_idx",  64'(out_col), 64'd3);
        chk("t2_col3",      out_data,     64'hFFFF_FFFF_FFFF_FFFD);
        drain_all("t2_drained");

        // Backpressure with ready pattern 1,0,0,1
        for (int c = 0; c < NCOL; c++) beat[c] = c * 1000 - 3500;
        send_beat(1'b1, w);
        for (int i = 0; i < 80 && sb.size() > 0; i++) begin
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            v0 = out_valid; r0 = out_ready; c0 = out_col; d0 = out_data;
            step();
            if (v0 && !r0) begin
                chk("t3_hold_col",  64'(out_col), 64'(c0));
                chk("t3_hold_data", out_data,     d0);
            end
        end
        chk("t3_drained", 64'(sb.size()), 64'd0);
        out_ready = 1'b1;
        step();

        // Last beat of the next group arrives mid-drain
        for (int c = 0; c < NCOL; c++) beat[c] = 10 + c;
        send_beat(1'b1, w);
        for (int c = 0; c < NCOL; c++) beat[c] = 1 + c;
        send_beat(1'b0, w);
        chk("t4_nonlast_wait", 64'(w), 64'd1);
        step();
        chk("t4_at_col2", 64'(out_col), 64'd2);
        for (int c = 0; c < NCOL; c++) beat[c] = 100 * c;
        send_beat(1'b1, w);
        chk("t4_stalled",     64'(ready_at_drive), 64'd0);
        chk("t4_stall_len",   64'(w),              64'd6);
        chk("t4_nobubble_v",  64'(out_valid),      64'd1);
        chk("t4_nobubble_c",  64'(out_col),        64'd0);
        chk("t4_new_col0",    out_data,            64'(macc[0]));
        drain_all("t4_drained");
        step();
        chk("t4_idle", 64'(out_valid), 64'd0);

        // 52-bit accumulator wraps
        w_psums[PW-1:0] = 52'h7_FFFF_FFFF_FFFF;
        w_psum_valid = 1'b1;
        step();
        w_psum_last = 1'b1;
        step();
        w_psum_valid = 1'b0; w_psum_last = 1'b0;
        chk("t5_valid",  64'(w_out_valid), 64'd1);
        chk("t5_col0",   64'(w_out_data),  64'h000F_FFFF_FFFF_FFFE);
        step();
        chk("t5_col1",   64'(w_out_data),  64'd0);
        repeat (8) step();
        chk("t5_idle",   64'(w_out_valid), 64'd0);

        // Reset mid-drain discards the buffer and the partial accumulation
        for (int c = 0; c < NCOL; c++) beat[c] = 7 * c + 1;
        send_beat(1'b1, w);
        for (int c = 0; c < NCOL; c++) beat[c] = 999;
        send_beat(1'b0, w);
        for (int i = 0; i < 20 && out_col != 3'd4; i++) step();
        chk("t6_at_col4", 64'(out_col), 64'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(out_valid),  64'd0);
        chk("t6_async_col",   64'(out_col),    64'd0);
        chk("t6_async_ready", 64'(psum_ready), 64'd1);
        sb.delete();
        mfirst = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t6_post_ready", 64'(psum_ready), 64'd1);
        chk("t6_post_valid", 64'(out_valid),  64'd0);
        for (int c = 0; c < NCOL; c++) beat[c] = -11 * c;
        send_beat(1'b1, w);
        chk("t6_new_col0", out_data, 64'd0);
        drain_all("t6_drained");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/psum_drain.md
# psum_drain

Output-side partner of the Bit Fusion systolic array top. It accepts the per-column partial-sum vector that the array presents each cycle and sums those vectors across input tiles into per-column signed accumulators. When a group completes, it moves the totals into a drain buffer. It then streams the buffer out one column per handshake, so accumulation of the next group overlaps with draining the previous one.

## Interface
- COL_WIDTH, 13: per-lane psum slice width; one column psum is COL_WIDTH*4 bits.
- ARRAY_SIZE, 8: number of array columns, which is also the number of accumulators.
- ACC_WIDTH, 64: accumulator and output width; must be ≥ COL_WIDTH*4.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- psum_valid  in  1  psums beat valid.
- psum_ready  out  1  beat accepted when psum_valid & psum_ready.
- psums  in  ARRAY_SIZE*COL_WIDTH*4  column c occupies bits [c*COL_WIDTH*4 +: COL_WIDTH*4], signed two's complement.
- psum_last  in  1  qualifies the final beat of an accumulation group.
- out_valid  out  1  drain word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  ACC_WIDTH  accumulated total for column out_col.
- out_col  out  $clog2(ARRAY_SIZE)  column index of out_data.
- out_last  out  1  high with the column ARRAY_SIZE-1 word.

## Operation
- Accept: in_fire = psum_valid & psum_ready. Out_fire = out_valid & out_ready.
- Each column psum is sign-extended to ACC_WIDTH. Additions wrap modulo 2^ACC_WIDTH with no saturation and no overflow flag.
- `first` flag, set at reset and after every accepted last beat:
  - in_fire with first=1: acc[c] <= ext(psum[c]).
  - in_fire with first=0: acc[c] <= acc[c] + ext(psum[c]).
  - first <= 0 after any non-last accept.
- in_fire with psum_last:
  - buf[c] <= (first ? 0 : acc[c]) + ext(psum[c]).
  - busy <= 1, out_col <= 0, first <= 1.
  - acc contents become don't-care.
- States:
  - IDLE (busy=0) -> DRAIN on an accepted last beat.
  - DRAIN: out_fire increments out_col. An out_fire at out_col=ARRAY_SIZE-1 returns to IDLE, unless a last beat is accepted in the same cycle, in which case the block reloads and stays in DRAIN with out_col=0.
- Outputs:
  - out_valid = busy.
  - out_data = buf[out_col].
  - out_last = busy & (out_col==ARRAY_SIZE-1).
  - All three are driven from registers only.
- psum_ready = ~busy | ~psum_last | (out_fire & out_last).
  - Non-last beats are always accepted, including during DRAIN.
  - A last beat stalls only while the buffer is still draining.
  - This is the only combinational input-to-output path.
- out_data must stay stable while out_valid & ~out_ready.

## Timing
- Reset values (async assert, sync deassert, applied to all state): psum_ready=1, out_valid=0, out_data=0, out_col=0, out_last=0, busy=0, first=1, acc=0, buf=0.
- Latency: a last beat accepted at edge N gives out_valid=1, out_col=0 after edge N.
  - With out_ready held high, column k is presented in cycle N+1+k.
  - busy clears after edge N+ARRAY_SIZE.
- Back-to-back groups, with the second last beat accepted exactly on the final out_fire: the next cycle shows out_col=0 of the new group with no bubble.
- Single-beat group, i.e. psum_last on a first beat: totals equal the sign-extended psums.
- Reset mid-DRAIN: the remaining words are discarded, out_valid drops asynchronously, and the partial accumulation is lost.

## Test plan
1. Single-beat group: all columns psum=5, psum_last=1, out_ready=1 → 8 words of 5, cols 0..7, out_last only on col 7, out_valid high for exactly 8 cycles.
2. Three-beat group, signed: col 0 psums 100, -300, 7 and col 3 psums all -1 → col0=-193 (64'hFFFF_FFFF_FFFF_FF3F) and col3=-3; other columns are 0 when fed 0.
3. Backpressure: toggle out_ready 1,0,0,1… → out_col and out_data hold while ready is low; every column is output exactly once, in order.
4. Last beat during drain: a second group's last beat arrives while col 2 is draining → psum_ready=0 until the col 7 out_fire cycle. The beat is accepted on that cycle and the next cycle shows the new group's col 0. Non-last beats sent during the drain are accepted.
5. Wrap: ACC_WIDTH=52 configuration, two beats of 2^51-1 → result -2 (wrapped), no error.
6. Reset mid-drain: assert rst_n=0 at col 4 → out_valid=0 immediately. After release, psum_ready=1, and a new single-beat group drains only its own values.
